// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core: opcode encodings, default widths
// and the fetch-stage state encoding.
package cpu_pkg;

  localparam int CPU_IW = 16;
  localparam int CPU_AW = 16;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_SLT = 4'h7;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'hA;
  localparam logic [3:0] OP_BNE = 4'hE;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_REQ   = 2'd1,
    FS_FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding an instruction and its pc; clear wins over push,
// push wins over pop, so a push in the same cycle as a pop keeps the new entry.
module fetch_skid
  import cpu_pkg::*;
#(
  parameter int IW = CPU_IW,
  parameter int AW = CPU_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [IW-1:0] push_instr,
  input  logic [AW-1:0] push_pc,
  output logic          sk_valid,
  output logic [IW-1:0] sk_instr,
  output logic [AW-1:0] sk_pc
);

  logic          sk_valid_q, sk_valid_d;
  logic [IW-1:0] sk_instr_q, sk_instr_d;
  logic [AW-1:0] sk_pc_q, sk_pc_d;

  always_comb begin
    sk_valid_d = sk_valid_q;
    sk_instr_d = sk_instr_q;
    sk_pc_d    = sk_pc_q;
    if (clear) begin
      sk_valid_d = 1'b0;
    end else if (push) begin
      sk_valid_d = 1'b1;
      sk_instr_d = push_instr;
      sk_pc_d    = push_pc;
    end else if (pop) begin
      sk_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sk_valid_q <= 1'b0;
      sk_instr_q <= '0;
      sk_pc_q    <= '0;
    end else begin
      sk_valid_q <= sk_valid_d;
      sk_instr_q <= sk_instr_d;
      sk_pc_q    <= sk_pc_d;
    end
  end

  assign sk_valid = sk_valid_q;
  assign sk_instr = sk_instr_q;
  assign sk_pc    = sk_pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the pc, runs req/ack to imem, ack in cycle N gives if_valid in N+1.
// A stalled decode parks one response in the skid and drops imem_req until it drains.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int              IW       = CPU_IW,
  parameter int              AW       = CPU_AW,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          if_valid,
  output logic [IW-1:0] if_instr,
  output logic [3:0]    if_op,
  output logic [AW-1:0] if_pc,
  output logic [AW-1:0] if_pc_plus1
);

  localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] pending_pc_q, pending_pc_d;
  logic          if_valid_q, if_valid_d;
  logic [IW-1:0] if_instr_q, if_instr_d;
  logic [AW-1:0] if_pc_q, if_pc_d;

  logic          sk_push, sk_pop, sk_clear;
  logic          sk_valid;
  logic [IW-1:0] sk_instr;
  logic [AW-1:0] sk_pc;
  logic          consume;
  logic          out_free;

  assign consume  = if_valid_q && !stall;
  // The output slot can take new data only if it drains this cycle and no skid entry is queued ahead.
  assign out_free = (!if_valid_q || consume) && !sk_valid;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    sk_push      = 1'b0;
    sk_pop       = 1'b0;
    sk_clear     = 1'b0;

    if (redirect_valid) begin
      if_valid_d = 1'b0;
      sk_clear   = 1'b1;
      // An unanswered request cannot be withdrawn; its response must be swallowed first.
      if (state_q != FS_IDLE && !imem_ack) begin
        pending_pc_d = redirect_pc;
        state_d      = FS_FLUSH;
      end else begin
        fetch_pc_d = redirect_pc;
        state_d    = FS_REQ;
      end
    end else begin
      if (consume) begin
        if (sk_valid) begin
          if_valid_d = 1'b1;
          if_instr_d = sk_instr;
          if_pc_d    = sk_pc;
          sk_pop     = 1'b1;
        end else begin
          if_valid_d = 1'b0;
        end
      end

      case (state_q)
        FS_IDLE: begin
          if (!sk_valid || sk_pop) state_d = FS_REQ;
        end
        FS_REQ: begin
          if (imem_ack) begin
            fetch_pc_d = fetch_pc_q + PC_ONE;
            if (out_free) begin
              if_valid_d = 1'b1;
              if_instr_d = imem_rdata;
              if_pc_d    = fetch_pc_q;
              state_d    = FS_REQ;
            end else begin
              sk_push = 1'b1;
              state_d = FS_IDLE;
            end
          end
        end
        FS_FLUSH: begin
          if (imem_ack) begin
            fetch_pc_d = pending_pc_q;
            state_d    = FS_REQ;
          end
        end
        default: state_d = FS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FS_IDLE;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
    end
  end

  fetch_skid #(
    .IW(IW),
    .AW(AW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (sk_push),
    .pop       (sk_pop),
    .clear     (sk_clear),
    .push_instr(imem_rdata),
    .push_pc   (fetch_pc_q),
    .sk_valid  (sk_valid),
    .sk_instr  (sk_instr),
    .sk_pc     (sk_pc)
  );

  assign imem_req    = (state_q != FS_IDLE);
  assign imem_addr   = fetch_pc_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_op       = if_instr_q[IW-1:IW-4];
  assign if_pc       = if_pc_q;
  assign if_pc_plus1 = if_pc_q + PC_ONE;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a per-cycle vector table from reset release,
// followed by hand-written reset sequences (skid full, request outstanding).
module tb_instr_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [3:0]  if_op;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_fetch #(.IW(16), .AW(16), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_op         (if_op),
    .if_pc         (if_pc),
    .if_pc_plus1   (if_pc_plus1)
  );

  typedef struct {
    logic        ack;
    logic [15:0] rdata;
    logic        stall;
    logic        rv;
    logic [15:0] rpc;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_vld;
    logic [15:0] e_pc;
    logic [15:0] e_instr;
  } vec_t;

  localparam int NV = 42;
  vec_t vec [NV];

  function automatic vec_t v(input logic ack, input logic [15:0] rdata, input logic stl,
                             input logic rv, input logic [15:0] rpc, input logic e_req,
                             input logic [15:0] e_addr, input logic e_vld,
                             input logic [15:0] e_pc, input logic [15:0] e_instr);
    vec_t r;
    r.ack = ack; r.rdata = rdata; r.stall = stl; r.rv = rv; r.rpc = rpc;
    r.e_req = e_req; r.e_addr = e_addr; r.e_vld = e_vld; r.e_pc = e_pc; r.e_instr = e_instr;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_reset(input int tag);
    chk("rst_req",   tag, 32'(imem_req),    32'h0);
    chk("rst_addr",  tag, 32'(imem_addr),   32'h0);
    chk("rst_vld",   tag, 32'(if_valid),    32'h0);
    chk("rst_instr", tag, 32'(if_instr),    32'h0);
    chk("rst_pc",    tag, 32'(if_pc),       32'h0);
    chk("rst_op",    tag, 32'(if_op),       32'(OP_AND));
    chk("rst_pc1",   tag, 32'(if_pc_plus1), 32'h1);
  endtask

  initial begin
    logic [15:0] exp_pc1;

    //          ack rdata    stl rv rpc       req addr     vld pc       instr
    vec[0]  = v(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    vec[1]  = v(1, 16'h2123, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    vec[2]  = v(1, 16'h6456, 0, 0, 16'h0000, 1, 16'h0001, 1, 16'h0000, 16'h2123);
    vec[3]  = v(1, 16'h0789, 0, 0, 16'h0000, 1, 16'h0002, 1, 16'h0001, 16'h6456);
    vec[4]  = v(1, 16'h1AAA, 1, 0, 16'h0000, 1, 16'h0003, 1, 16'h0002, 16'h0789);
    vec[5]  = v(0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0004, 1, 16'h0002, 16'h0789);
    vec[6]  = v(0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0004, 1, 16'h0002, 16'h0789);
    vec[7]  = v(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0004, 1, 16'h0002, 16'h0789);
    vec[8]  = v(1, 16'h2BBB, 0, 0, 16'h0000, 1, 16'h0004, 1, 16'h0003, 16'h1AAA);
    vec[9]  = v(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0005, 1, 16'h0004, 16'h2BBB);
    vec[10] = v(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0005, 0, 16'h0000, 16'h0000);
    vec[11] = v(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0005, 0, 16'h0000, 16'h0000);
    vec[12] = v(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0005, 0, 16'h0000, 16'h0000);
    vec[13] = v(1, 16'h8CCC, 0, 0, 16'h0000, 1, 16'h0005, 0, 16'h0000, 16'h0000);
    vec[14] = v(1, 16'h6DDD, 0, 0, 16'h0000, 1, 16'h0006, 1, 16'h0005, 16'h8CCC);
    vec[15] = v(0, 16'h0000, 0, 1, 16'h0040, 1, 16'h0007, 1, 16'h0006, 16'h6DDD);
    vec[16] = v(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0007, 0, 16'h0000, 16'h0000);
    vec[17] = v(1, 16'hEEEE, 0, 0, 16'h0000, 1, 16'h0007, 0, 16'h0000, 16'h0000);
    vec[18] = v(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 16'h0000);
    vec[19] = v(1, 16'h7040, 0, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 16'h0000);
    vec[20] = v(1, 16'hA041, 0, 0, 16'h0000, 1, 16'h0041, 1, 16'h0040, 16'h7040);
    vec[21] = v(1, 16'h0042, 0, 1, 16'h0009, 1, 16'h0042, 1, 16'h0041, 16'hA041);
    vec[22] = v(1, 16'h1999, 0, 1, 16'h0100, 1, 16'h0009, 0, 16'h0000, 16'h0000);
    vec[23] = v(1, 16'h2100, 0, 0, 16'h0000, 1, 16'h0100, 0, 16'h0000, 16'h0000);
    vec[24] = v(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0101, 1, 16'h0100, 16'h2100);
    vec[25] = v(0, 16'h0000, 0, 1, 16'hFFFF, 1, 16'h0101, 0, 16'h0000, 16'h0000);
    vec[26] = v(1, 16'h3333, 0, 0, 16'h0000, 1, 16'h0101, 0, 16'h0000, 16'h0000);
    vec[27] = v(1, 16'h7FFF, 0, 0, 16'h0000, 1, 16'hFFFF, 0, 16'h0000, 16'h0000);
    vec[28] = v(0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0000, 1, 16'hFFFF, 16'h7FFF);
    vec[29] = v(0, 16'h0000, 1, 1, 16'h0200, 1, 16'h0000, 1, 16'hFFFF, 16'h7FFF);
    vec[30] = v(0, 16'h0000, 0, 1, 16'h0300, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    vec[31] = v(1, 16'h4444, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    vec[32] = v(1, 16'h5300, 0, 0, 16'h0000, 1, 16'h0300, 0, 16'h0000, 16'h0000);
    vec[33] = v(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0301, 1, 16'h0300, 16'h5300);
    vec[34] = v(0, 16'h0000, 0, 1, 16'h0500, 1, 16'h0301, 0, 16'h0000, 16'h0000);
    vec[35] = v(1, 16'h1111, 0, 1, 16'h0600, 1, 16'h0301, 0, 16'h0000, 16'h0000);
    vec[36] = v(1, 16'h6600, 0, 0, 16'h0000, 1, 16'h0600, 0, 16'h0000, 16'h0000);
    vec[37] = v(0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0601, 1, 16'h0600, 16'h6600);
    vec[38] = v(1, 16'h1601, 1, 0, 16'h0000, 1, 16'h0601, 1, 16'h0600, 16'h6600);
    vec[39] = v(0, 16'h0000, 1, 1, 16'h0700, 0, 16'h0602, 1, 16'h0600, 16'h6600);
    vec[40] = v(1, 16'h2700, 0, 0, 16'h0000, 1, 16'h0700, 0, 16'h0000, 16'h0000);
    vec[41] = v(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0701, 1, 16'h0700, 16'h2700);

    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) @(negedge clk);
    #1 chk_reset(-1);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      imem_ack       = vec[i].ack;
      imem_rdata     = vec[i].rdata;
      stall          = vec[i].stall;
      redirect_valid = vec[i].rv;
      redirect_pc    = vec[i].rpc;
      #1;
      chk("req",  i, 32'(imem_req),  32'(vec[i].e_req));
      chk("addr", i, 32'(imem_addr), 32'(vec[i].e_addr));
      chk("vld",  i, 32'(if_valid),  32'(vec[i].e_vld));
      if (vec[i].e_vld) begin
        exp_pc1 = vec[i].e_pc + 16'd1;
        chk("pc",    i, 32'(if_pc),       32'(vec[i].e_pc));
        chk("instr", i, 32'(if_instr),    32'(vec[i].e_instr));
        chk("op",    i, 32'(if_op),       32'(vec[i].e_instr[15:12]));
        chk("pc1",   i, 32'(if_pc_plus1), 32'(exp_pc1));
      end
      @(negedge clk);
    end

    // Fill output and skid under stall, then reset asynchronously.
    stall = 1'b1;
    redirect_valid = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 16'h1701;
    @(negedge clk);
    imem_rdata = 16'h1702;
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    chk("full_req", 100, 32'(imem_req), 32'h0);
    chk("full_vld", 100, 32'(if_valid), 32'h1);
    chk("full_pc",  100, 32'(if_pc),    32'h0701);
    #2 rst_n = 1'b0;
    #1 chk_reset(101);

    // Release with a stray ack present: it must be ignored.
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 16'hDEAD;
    #1 chk("late_req", 102, 32'(imem_req), 32'h0);
    @(negedge clk);
    imem_rdata = 16'h2123;
    #1;
    chk("rs_req",  103, 32'(imem_req),  32'h1);
    chk("rs_addr", 103, 32'(imem_addr), 32'h0);
    chk("rs_vld",  103, 32'(if_valid),  32'h0);
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    chk("rs_vld2",  104, 32'(if_valid), 32'h1);
    chk("rs_pc",    104, 32'(if_pc),    32'h0);
    chk("rs_instr", 104, 32'(if_instr), 32'h2123);
    chk("rs_op",    104, 32'(if_op),    32'(OP_ADD));
    chk("rs_addr2", 104, 32'(imem_addr), 32'h1);
    chk("rs_req2",  104, 32'(imem_req),  32'h1);

    // Reset while a request is outstanding drops imem_req at once.
    #2 rst_n = 1'b0;
    #1 chk_reset(105);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
